// File: rtl/rv_wb_timer.sv
// rv_wb_timer: Wishbone classic responder exposing a RISC-V machine timer
// (64-bit mtime/mtimecmp, prescaler, registered level interrupt).
module rv_wb_timer #(
    parameter int unsigned WAIT_STATES    = 0,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_dat,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_stb,
    input  logic        i_wb_cyc,
    output logic        o_wb_ack,
    output logic        o_irq
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                wcnt_q, wcnt_d;
    logic [2:0]                adr_q;
    logic [31:0]               dat_q;
    logic                      we_q;
    logic [3:0]                sel_q;
    logic [63:0]               mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [1:0]                ctrl_q, ctrl_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
    logic [31:0]               shadow_q, shadow_d, rdata_q, rdata_d;
    logic                      irq_q;
    logic                      req, to_ack, commit, tick, ge, cur_we;
    logic [2:0]                cur_adr;
    logic [31:0]               rd, wold, wnew;
    logic                      unused_adr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    assign unused_adr = ^{i_wb_adr[31:5], i_wb_adr[1:0]};
    assign req        = i_wb_cyc && i_wb_stb;
    assign ge         = mtime_q >= mtimecmp_q;
    assign tick       = ctrl_q[0] && (pcnt_q == prescale_q);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: if (req) begin
                state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
                wcnt_d  = 4'(WAIT_STATES - 1);
            end
            S_WAIT: if (!i_wb_cyc) state_d = S_IDLE;
                    else if (wcnt_q == '0) state_d = S_ACK;
                    else wcnt_d = wcnt_q - 4'd1;
            default: state_d = S_IDLE;
        endcase
    end

    // Zero-wait requests reach ACK straight from IDLE, so read the live bus there.
    always_comb begin
        o_wb_ack = state_q == S_ACK;
        commit   = (state_q == S_ACK) && we_q;
        to_ack   = (state_d == S_ACK) && (state_q != S_ACK);
        cur_adr  = (state_q == S_IDLE) ? i_wb_adr[4:2] : adr_q;
        cur_we   = (state_q == S_IDLE) ? i_wb_we : we_q;
    end

    always_comb begin
        case (cur_adr)
            3'd0:    rd = mtime_q[31:0];
            3'd1:    rd = shadow_q;
            3'd2:    rd = mtimecmp_q[31:0];
            3'd3:    rd = mtimecmp_q[63:32];
            3'd4:    rd = 32'(ctrl_q);
            3'd5:    rd = 32'(prescale_q);
            3'd6:    rd = 32'(ge);
            default: rd = '0;
        endcase
        case (adr_q)
            3'd0:    wold = mtime_q[31:0];
            3'd1:    wold = mtime_q[63:32];
            3'd2:    wold = mtimecmp_q[31:0];
            3'd3:    wold = mtimecmp_q[63:32];
            3'd4:    wold = 32'(ctrl_q);
            3'd5:    wold = 32'(prescale_q);
            default: wold = '0;
        endcase
        wnew       = merge(wold, dat_q, sel_q);
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pcnt_d     = ctrl_q[0] ? (tick ? '0 : pcnt_q + 1'b1) : pcnt_q;
        rdata_d    = to_ack ? rd : '0;
        shadow_d   = (to_ack && !cur_we && cur_adr == 3'd0) ? mtime_q[63:32] : shadow_q;
        // A bus write to mtime replaces the whole next value, dropping any tick.
        if (commit) begin
            case (adr_q)
                3'd0: mtime_d    = {mtime_q[63:32], wnew};
                3'd1: mtime_d    = {wnew, mtime_q[31:0]};
                3'd2: mtimecmp_d = {mtimecmp_q[63:32], wnew};
                3'd3: mtimecmp_d = {wnew, mtimecmp_q[31:0]};
                3'd4: ctrl_d     = wnew[1:0];
                3'd5: begin
                    prescale_d = wnew[PRESCALE_WIDTH-1:0];
                    pcnt_d     = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            adr_q      <= '0;
            dat_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            ctrl_q     <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            shadow_q   <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (state_q == S_IDLE && req) begin
                adr_q <= i_wb_adr[4:2];
                dat_q <= i_wb_dat;
                we_q  <= i_wb_we;
                sel_q <= i_wb_sel;
            end
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            shadow_q   <= shadow_d;
            rdata_q    <= rdata_d;
            irq_q      <= ctrl_q[1] && ge;
        end
    end

    assign o_wb_dat = rdata_q;
    assign o_irq    = irq_q;
endmodule

// File: tb/tb_rv_wb_timer.sv
// tb_rv_wb_timer: directed self-checking bench for rv_wb_timer with
// zero, two and three wait-state instances sharing one bus.
module tb_rv_wb_timer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr = '0, wdat = '0;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic        cyc [3];
    logic        stb [3];
    logic        ack [3];
    logic        irq [3];
    logic [31:0] rdat [3];
    int          tests = 0, fails = 0;
    logic [31:0] r, r1, r2;
    int          lat;

    always #5 clk = ~clk;

    rv_wb_timer #(.WAIT_STATES(0)) u0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_wb_adr(adr), .i_wb_dat(wdat), .o_wb_dat(rdat[0]),
        .i_wb_we(we), .i_wb_sel(sel), .i_wb_stb(stb[0]), .i_wb_cyc(cyc[0]),
        .o_wb_ack(ack[0]), .o_irq(irq[0]));
    rv_wb_timer #(.WAIT_STATES(2)) u2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_wb_adr(adr), .i_wb_dat(wdat), .o_wb_dat(rdat[1]),
        .i_wb_we(we), .i_wb_sel(sel), .i_wb_stb(stb[1]), .i_wb_cyc(cyc[1]),
        .o_wb_ack(ack[1]), .o_irq(irq[1]));
    rv_wb_timer #(.WAIT_STATES(3)) u3 (
        .i_clk(clk), .i_reset_n(rst_n), .i_wb_adr(adr), .i_wb_dat(wdat), .o_wb_dat(rdat[2]),
        .i_wb_we(we), .i_wb_sel(sel), .i_wb_stb(stb[2]), .i_wb_cyc(cyc[2]),
        .o_wb_ack(ack[2]), .o_irq(irq[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one transfer at a negedge and returns at the negedge where ack is seen.
    task automatic bus(input int d, input logic w, input logic [2:0] a, input logic [31:0] data,
                       input logic [3:0] s, output logic [31:0] rd, output int lt);
        logic got;
        got = 1'b0;
        rd  = '0;
        @(negedge clk);
        adr = {27'b0, a, 2'b00}; wdat = data; we = w; sel = s; cyc[d] = 1'b1; stb[d] = 1'b1;
        lt = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lt++;
            if (ack[d]) begin
                got = 1'b1;
                rd  = rdat[d];
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0; we = 1'b0;
        check("ack_seen", 64'(got), 64'd1);
    endtask

    task automatic wr(input int d, input logic [2:0] a, input logic [31:0] data);
        logic [31:0] dummy;
        int l;
        bus(d, 1'b1, a, data, 4'hF, dummy, l);
    endtask

    task automatic rdr(input int d, input logic [2:0] a, output logic [31:0] v);
        int l;
        bus(d, 1'b0, a, '0, 4'hF, v, l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin cyc[i] = 1'b0; stb[i] = 1'b0; end
        repeat (3) @(negedge clk);
        check("rst_ack", 64'(ack[0]), 0);
        check("rst_dat", 64'(rdat[0]), 0);
        check("rst_irq", 64'(irq[0]), 0);
        rst_n = 1'b1;

        // Reset in the middle of a WAIT on the 3-wait-state instance
        @(negedge clk);
        adr = 32'h10; wdat = 32'h3; we = 1'b1; sel = 4'hF; cyc[2] = 1'b1; stb[2] = 1'b1;
        repeat (2) @(negedge clk);
        check("midwait_ack", 64'(ack[2]), 0);
        #2 rst_n = 1'b0;
        #1 check("rst_async_ack", 64'(ack[2]), 0);
        cyc[2] = 1'b0; stb[2] = 1'b0; we = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_ack", 64'(ack[2]), 0);
        end
        rst_n = 1'b1;
        rdr(2, 3'd2, r);
        check("rst_cmp_lo", r, 32'hFFFF_FFFF);
        rdr(2, 3'd4, r);
        check("rst_ctrl", r, 0);

        // Handshake latency and single-cycle ack
        bus(0, 1'b1, 3'd4, 32'h3, 4'hF, r, lat);
        check("lat_ws0", 64'(lat), 2);
        @(negedge clk);
        check("ack_one_cycle", 64'(ack[0]), 0);
        rdr(0, 3'd4, r);
        check("ctrl_rb", r, 3);
        wr(0, 3'd4, 0);
        bus(1, 1'b1, 3'd4, 32'h3, 4'hF, r, lat);
        check("lat_ws2", 64'(lat), 4);
        @(negedge clk);
        adr = 32'h10; wdat = 32'h0; we = 1'b1; sel = 4'hF; cyc[1] = 1'b1; stb[1] = 1'b1;
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0; we = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_ack", 64'(ack[1]), 0);
        end
        rdr(1, 3'd4, r);
        check("abort_ctrl", r, 3);

        // Byte lanes, sel=0 and reserved register
        bus(0, 1'b1, 3'd5, 32'h1234_5678, 4'b0001, r, lat);
        rdr(0, 3'd5, r);
        check("lane0_prescale", r, 32'h78);
        bus(0, 1'b1, 3'd5, 32'hFFFF_FFFF, 4'b0000, r, lat);
        rdr(0, 3'd5, r);
        check("sel0_prescale", r, 32'h78);
        wr(0, 3'd7, 32'hFFFF_FFFF);
        rdr(0, 3'd7, r);
        check("reserved_rd", r, 0);

        // Prescaled counting: 40 cycles between snapshots at PRESCALE=3
        wr(0, 3'd0, 0); wr(0, 3'd1, 0); wr(0, 3'd5, 3); wr(0, 3'd4, 1);
        rdr(0, 3'd0, r1);
        repeat (38) @(negedge clk);
        rdr(0, 3'd0, r2);
        check("count_div4", r2 - r1, 10);

        // 32-bit carry into MTIME_HI
        wr(0, 3'd4, 0); wr(0, 3'd0, 32'hFFFF_FFFF); wr(0, 3'd1, 0); wr(0, 3'd5, 3); wr(0, 3'd4, 1);
        rdr(0, 3'd0, r);
        check("carry_lo_pre", r, 32'hFFFF_FFFF);
        rdr(0, 3'd1, r);
        check("carry_hi_pre", r, 0);
        rdr(0, 3'd0, r);
        check("carry_lo_post", r, 0);
        rdr(0, 3'd1, r);
        check("carry_hi_post", r, 1);

        // Atomic LO/HI read with ticks in between, then write beats tick
        wr(0, 3'd4, 0); wr(0, 3'd0, 32'hFFFF_FFFF); wr(0, 3'd1, 1); wr(0, 3'd5, 0); wr(0, 3'd4, 1);
        rdr(0, 3'd0, r);
        check("atomic_lo", r, 32'hFFFF_FFFF);
        rdr(0, 3'd1, r);
        check("atomic_hi", r, 1);
        wr(0, 3'd0, 100);
        rdr(0, 3'd0, r);
        check("write_beats_tick", r, 100);

        // Interrupt
        wr(0, 3'd4, 0); wr(0, 3'd0, 0); wr(0, 3'd1, 0); wr(0, 3'd5, 0);
        wr(0, 3'd3, 0); wr(0, 3'd2, 10);
        check("irq_idle", 64'(irq[0]), 0);
        wr(0, 3'd4, 3);
        repeat (11) @(negedge clk);
        check("irq_before", 64'(irq[0]), 0);
        @(negedge clk);
        check("irq_rise", 64'(irq[0]), 1);
        rdr(0, 3'd6, r);
        check("status_set", r, 1);
        wr(0, 3'd2, 1000);
        @(negedge clk);
        check("irq_hold", 64'(irq[0]), 1);
        @(negedge clk);
        check("irq_clear", 64'(irq[0]), 0);
        rdr(0, 3'd6, r);
        check("status_clr", r, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
